// File: rtl/tile_pkg.sv
// Shared definitions for the tile renderer: draw modes, fixed colours,
// FSM state encoding and a board-extent helper for configuration checks.
package tile_pkg;

    localparam logic [1:0] MODE_LIT    = 2'b00;
    localparam logic [1:0] MODE_ERASE  = 2'b01;
    localparam logic [1:0] MODE_HILITE = 2'b10;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Far edge (exclusive) of the board along one axis.
    function automatic int board_extent(int n, int size, int gap, int origin);
        return origin + n * size + (n - 1) * gap;
    endfunction

endpackage

// File: rtl/tile_coord.sv
// Combinational tile lookup: tile index + mode -> top-left pixel, colour and
// a range flag. Also used by the board-clear logic.
module tile_coord
    import tile_pkg::*;
#(
    parameter int GRID_COLS = 2,
    parameter int GRID_ROWS = 2,
    parameter int TILE_SIZE = 8,
    parameter int GAP       = 0,
    parameter int X_ORIGIN  = 0,
    parameter int Y_ORIGIN  = 0,
    parameter int TW        = 2
) (
    input  logic [TW-1:0] tile_i,
    input  logic [1:0]    mode_i,
    output logic [8:0]    bx_o,
    output logic [7:0]    by_o,
    output logic [2:0]    colour_o,
    output logic          in_range_o
);

    localparam logic [31:0] COLS  = 32'(GRID_COLS);
    localparam logic [31:0] PITCH = 32'(TILE_SIZE + GAP);
    localparam logic [31:0] XO    = 32'(X_ORIGIN);
    localparam logic [31:0] YO    = 32'(Y_ORIGIN);
    localparam logic [31:0] NT    = 32'(GRID_COLS * GRID_ROWS);

    assign bx_o       = 9'(XO + (32'(tile_i) % COLS) * PITCH);
    assign by_o       = 8'(YO + (32'(tile_i) / COLS) * PITCH);
    assign in_range_o = 32'(tile_i) < NT;

    // Lit tiles cycle through the seven non-black colours; 11 falls back to lit.
    always_comb begin
        colour_o = 3'((32'(tile_i) % 32'd7) + 32'd1);
        case (mode_i)
            MODE_ERASE:  colour_o = COL_BLACK;
            MODE_HILITE: colour_o = COL_WHITE;
            default:     ;
        endcase
    end

endmodule

// File: rtl/tile_painter.sv
// Tile renderer: on an accepted start, sweeps every pixel of one tile in
// raster order (dx fastest), one registered plot per cycle, then pulses done.
module tile_painter
    import tile_pkg::*;
#(
    parameter int GRID_COLS = 2,
    parameter int GRID_ROWS = 2,
    parameter int TILE_SIZE = 8,
    parameter int GAP       = 0,
    parameter int X_ORIGIN  = 0,
    parameter int Y_ORIGIN  = 0,
    localparam int NUM_TILES = GRID_COLS * GRID_ROWS,
    localparam int TW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [TW-1:0] tile,
    input  logic [1:0]    mode,
    output logic          ready,
    output logic          plot,
    output logic [7:0]    x,
    output logic [6:0]    y,
    output logic [2:0]    colour,
    output logic          done
);

    localparam int CW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(TILE_SIZE - 1);
    localparam int BOARD_W = board_extent(GRID_COLS, TILE_SIZE, GAP, X_ORIGIN);
    localparam int BOARD_H = board_extent(GRID_ROWS, TILE_SIZE, GAP, Y_ORIGIN);

    if (BOARD_W > 160 || BOARD_H > 120) begin : g_board_too_big
        $error("tile_painter: board %0dx%0d exceeds 160x120", BOARD_W, BOARD_H);
    end

    state_e        state_q, state_d;
    logic [8:0]    bx_q, bx_d;
    logic [7:0]    by_q, by_d;
    logic [CW-1:0] dx_q, dx_d, dy_q, dy_d;
    logic          plot_q, plot_d, done_q, done_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;

    logic [8:0]    c_bx;
    logic [7:0]    c_by;
    logic [2:0]    c_colour;
    logic          c_in_range;
    logic          last_px;

    tile_coord #(
        .GRID_COLS(GRID_COLS), .GRID_ROWS(GRID_ROWS), .TILE_SIZE(TILE_SIZE),
        .GAP(GAP), .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN), .TW(TW)
    ) u_coord (
        .tile_i    (tile),
        .mode_i    (mode),
        .bx_o      (c_bx),
        .by_o      (c_by),
        .colour_o  (c_colour),
        .in_range_o(c_in_range)
    );

    assign last_px = (dx_q == LAST) && (dy_q == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: out-of-range tiles skip straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = c_in_range ? ST_DRAW : ST_DONE;
            ST_DRAW: if (last_px) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; x/y/colour hold whenever nothing is plotted.
    always_comb begin
        bx_d     = bx_q;
        by_d     = by_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dx_d = '0;
                    dy_d = '0;
                    if (c_in_range) begin
                        bx_d     = c_bx;
                        by_d     = c_by;
                        colour_d = c_colour;
                        plot_d   = 1'b1;
                        x_d      = c_bx[7:0];
                        y_d      = c_by[6:0];
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_DRAW: begin
                if (last_px) begin
                    done_d = 1'b1;
                end else begin
                    plot_d = 1'b1;
                    if (dx_q == LAST) begin
                        dx_d = '0;
                        dy_d = dy_q + CW'(1);
                    end else begin
                        dx_d = dx_q + CW'(1);
                    end
                    x_d = 8'(bx_q + 9'(dx_d));
                    y_d = 7'(by_q + 8'(dy_d));
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bx_q     <= '0;
            by_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= COL_BLACK;
        end else begin
            bx_q     <= bx_d;
            by_q     <= by_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign plot   = plot_q;
    assign done   = done_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;

endmodule

// File: tb/tb_tile_painter.sv
// Bench for tile_painter: a default 2x2 board and a 3x3 board with gaps,
// checked cycle by cycle against a pixel-list model built from tile geometry.
module tb_tile_painter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0, start0, ready0, plot0, done0;
    logic [1:0] tile0, mode0;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [2:0] colour0;

    logic       reset3, start3, ready3, plot3, done3;
    logic [3:0] tile3;
    logic [1:0] mode3;
    logic [7:0] x3;
    logic [6:0] y3;
    logic [2:0] colour3;

    tile_painter dut0 (
        .clk(clk), .reset(reset0), .start(start0), .tile(tile0), .mode(mode0),
        .ready(ready0), .plot(plot0), .x(x0), .y(y0), .colour(colour0), .done(done0)
    );

    tile_painter #(.GRID_COLS(3), .GRID_ROWS(3), .TILE_SIZE(8), .GAP(2)) dut3 (
        .clk(clk), .reset(reset3), .start(start3), .tile(tile3), .mode(mode3),
        .ready(ready3), .plot(plot3), .x(x3), .y(y3), .colour(colour3), .done(done3)
    );

    int checks = 0;
    int failures = 0;
    logic [17:0] last_pix [2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {ready, plot, done, x, y, colour}
    function automatic logic [20:0] outs(int inst);
        if (inst == 0) return {ready0, plot0, done0, x0, y0, colour0};
        return {ready3, plot3, done3, x3, y3, colour3};
    endfunction

    task automatic chk(string tag, logic [20:0] obs, logic [20:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(int inst, logic s, int t, int m);
        if (inst == 0) begin
            start0 = s; tile0 = 2'(t); mode0 = 2'(m);
        end else begin
            start3 = s; tile3 = 4'(t); mode3 = 2'(m);
        end
    endtask

    // Pixel i of tile t: raster order inside the tile, tiles laid out row-major.
    function automatic logic [17:0] exp_pix(int inst, int t, int m, int i);
        int cols = (inst == 0) ? 2 : 3;
        int gap  = (inst == 0) ? 0 : 2;
        int px   = (t % cols) * (8 + gap) + (i % 8);
        int py   = (t / cols) * (8 + gap) + (i / 8);
        int c    = (m == 1) ? 0 : (m == 2) ? 7 : (t % 7) + 1;
        logic [7:0] xv = 8'(px);
        logic [6:0] yv = 7'(py);
        logic [2:0] cv = 3'(c);
        return {xv, yv, cv};
    endfunction

    task automatic idle(int inst, int n);
        for (int k = 0; k < n; k++) begin
            drive(inst, 1'b0, 0, 0);
            step();
            chk("idle", outs(inst), {3'b100, last_pix[inst]});
        end
    endtask

    // Called in a cycle where the DUT is ready; start is accepted at the next edge.
    task automatic run_tile(int inst, int t, int m, bit hold, int pulse_at, int reset_at);
        int ntiles = (inst == 0) ? 4 : 9;
        logic [17:0] p;
        drive(inst, 1'b1, t, m);
        step();
        if (t >= ntiles) begin
            drive(inst, hold, t, m);
            chk("oor_done", outs(inst), {3'b001, last_pix[inst]});
            step();
            chk("oor_ready", outs(inst), {3'b100, last_pix[inst]});
            return;
        end
        for (int i = 0; i < 64; i++) begin
            drive(inst, hold || (i == pulse_at), (i == pulse_at) ? 1 : t, m);
            p = exp_pix(inst, t, m, i);
            chk($sformatf("pixel%0d_t%0d", i, t), outs(inst), {3'b010, p});
            last_pix[inst] = p;
            if (i == reset_at) begin
                if (inst == 0) reset0 = 1'b1; else reset3 = 1'b1;
                step();
                if (inst == 0) reset0 = 1'b0; else reset3 = 1'b0;
                drive(inst, 1'b0, t, m);
                last_pix[inst] = '0;
                chk("reset_abort", outs(inst), {3'b100, 18'b0});
                return;
            end
            step();
        end
        chk("done_pulse", outs(inst), {3'b001, last_pix[inst]});
        step();
        chk("ready_back", outs(inst), {3'b100, last_pix[inst]});
    endtask

    initial begin
        last_pix[0] = '0;
        last_pix[1] = '0;
        reset0 = 1'b1;
        reset3 = 1'b1;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        step();
        step();
        chk("reset_state0", outs(0), {3'b100, 18'b0});
        chk("reset_state3", outs(1), {3'b100, 18'b0});
        reset0 = 1'b0;
        reset3 = 1'b0;
        idle(0, 1);

        // Lit tile 2, then erase tile 3.
        run_tile(0, 2, 0, 1'b0, -1, -1);
        run_tile(0, 3, 1, 1'b0, -1, -1);

        // Start pulsed mid-draw is ignored and not queued.
        run_tile(0, 0, 0, 1'b0, 10, -1);
        idle(0, 2);

        // Reset abandons the tile; highlight tile 1 afterwards.
        run_tile(0, 0, 0, 1'b0, -1, 20);
        run_tile(0, 1, 2, 1'b0, -1, -1);

        // 3x3 board with gaps: in-range tile 4 and out-of-range tile 9.
        idle(1, 1);
        run_tile(1, 4, 0, 1'b0, -1, -1);
        run_tile(1, 9, 0, 1'b0, -1, -1);
        idle(1, 1);

        // Start held high: back-to-back acceptance with two dead cycles.
        run_tile(0, 0, 0, 1'b1, -1, -1);
        run_tile(0, 0, 0, 1'b1, -1, -1);
        idle(0, 2);

        // Randomized tiles, modes and idle gaps on both boards.
        for (int r = 0; r < 8; r++) begin
            run_tile(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, -1, -1);
            idle(0, int'($urandom_range(0, 2)));
        end
        for (int r = 0; r < 8; r++) begin
            run_tile(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0, -1, -1);
            idle(1, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
